// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the memory-bus arbiter.
package bus_arb_pkg;

  // Arbiter transfer phases
  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Fixed requester slots; 2 and 3 are spare
  localparam int unsigned REQ_LS    = 0;
  localparam int unsigned REQ_FETCH = 1;

  // Default configuration
  localparam int unsigned DEF_N_REQ       = 2;
  localparam int unsigned DEF_ADDR_W      = 16;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_TIMEOUT_CYC = 64;

  // Width of a requester index; never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from rr_ptr, or fixed
// priority with the lowest index winning.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = DEF_N_REQ,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned IDX_W      = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  // First set request in search order wins; search wraps modulo N_REQ
  always_comb begin
    int idx;
    gnt_oh = '0;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (FIXED_PRIO != 0) begin
        idx = int'(REQ_LS) + k;
      end else begin
        idx = (int'(rr_ptr) + k) % int'(N_REQ);
      end
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        winner      = IDX_W'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Memory-bus arbiter: picks one of N_REQ requesters (0 = load/store,
// 1 = fetch), drives the bus handshake and returns read data with a
// one-cycle done pulse. All outputs are registered.
// Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = DEF_N_REQ,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned FIXED_PRIO  = 0,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        err,
  output logic [DATA_W-1:0]       rdata,
  output logic                    bus_cs,
  output logic                    bus_we,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [DATA_W-1:0]       bus_wdata,
  input  logic                    bus_ready,
  input  logic [DATA_W-1:0]       bus_rdata
);

  localparam int unsigned IDX_W = idx_w(N_REQ);

  state_e state_q, state_d;

  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_cs_q, bus_cs_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             timeout;

  rr_pick #(
    .N_REQ      (N_REQ),
    .FIXED_PRIO (FIXED_PRIO),
    .IDX_W      (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt_oh (pick_gnt),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wdog_q, wdog_d;

  // Watchdog count: zero outside BUSY, so it starts cleared on every entry
  always_comb begin
    wdog_d = '0;
    if (state_q == StBusy) begin
      wdog_d = wdog_q + CNT_W'(1);
    end
  end

  // Watchdog register
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  // A ready in the final cycle takes precedence over the timeout
  assign timeout = (state_q == StBusy) && !bus_ready &&
                   (wdog_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid) state_d = StBusy;
      StBusy:  if (bus_ready || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and arbitration state
  always_comb begin
    gnt_d       = gnt_q;
    done_d      = done_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    bus_cs_d    = bus_cs_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          // Latch the winner's request so later changes on its inputs are ignored
          gnt_d       = pick_gnt;
          bus_cs_d    = 1'b1;
          bus_we_d    = req_we[pick_idx];
          bus_addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          bus_wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
          owner_d     = pick_idx;
          rr_ptr_d    = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      StBusy: begin
        if (bus_ready) begin
          rdata_d         = bus_rdata;
          bus_cs_d        = 1'b0;
          bus_we_d        = 1'b0;
          done_d[owner_q] = 1'b1;
        end else if (timeout) begin
          rdata_d         = '0;
          bus_cs_d        = 1'b0;
          bus_we_d        = 1'b0;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
        end
      end
      StDone: begin
        gnt_d  = '0;
        done_d = '0;
        err_d  = '0;
      end
      default: begin
        gnt_d    = '0;
        done_d   = '0;
        err_d    = '0;
        bus_cs_d = 1'b0;
        bus_we_d = 1'b0;
      end
    endcase
  end

  // Output and arbitration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      bus_cs_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      bus_cs_q    <= bus_cs_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_cs    = bus_cs_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule
